iq_stream_splitter: RTL and testbench
=====================================

# iq_stream_splitter

Front-end producer for the complex I/Q datapath. Reads a raw byte stream of interleaved 16-bit I/Q samples from one byte FIFO. Reassembles each sample pair, quantizes I and Q to 32-bit fixed point, and writes them to separate I and Q FIFOs. Those FIFOs feed the complex FIR channel filter, so this block is the writer side of the I/Q FIFO pair the filter reads.

## Interface
- BITS, 10, fixed-point fraction bits applied by quantization; legal range 0..16.
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- din  in  8  byte at head of input FIFO (first-word-fall-through; valid whenever in_empty=0).
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  pops input FIFO; combinational.
- i_out  out  32  quantized I sample.
- q_out  out  32  quantized Q sample.
- i_wr_en  out  1  write strobe to I FIFO; registered.
- q_wr_en  out  1  write strobe to Q FIFO; registered; always equal to i_wr_en.
- i_full  in  1  I FIFO full.
- q_full  in  1  Q FIFO full.
- sample_count  out  32  pairs emitted; present only with IQ_SAMPLE_COUNT_EN.

## Operation
- Byte order per pair is I_lo, I_hi, Q_lo, Q_hi. Each 16-bit value is little-endian, two's complement.
- FSM states:
  - S_I_LO, S_I_HI, S_Q_LO, S_Q_HI: when in_empty=0, assert in_rd_en, capture din into the matching byte register, and advance. When in_empty=1, hold with in_rd_en=0.
  - S_Q_HI advances to S_WRITE.
  - S_WRITE: when i_full=0 and q_full=0, load i_out/q_out, set both wr_en_c=1, and go to S_I_LO. Otherwise hold and read nothing.
  - Unreachable encodings go to S_I_LO.
- Quantization: sign-extend 16 to 32 bits, then shift left by BITS. The low BITS bits are zero. No overflow is possible for BITS ≤ 16.
- Writes are atomic: I and Q are written in the same cycle or not at all. A pair is never split.
- i_out/q_out hold their last written value between writes. They change only together with a wr_en assertion.
- Partial pairs are never emitted.
- Reset at any time discards any partial pair. The FSM restarts at S_I_LO.

## Timing
- Reset values:
  - i_out=0, q_out=0, i_wr_en=0, q_wr_en=0, sample_count=0.
  - State S_I_LO.
  - in_rd_en is forced 0 while reset is high.
- in_rd_en is combinational: high in the same cycle the byte is consumed.
- Minimum latency: the fourth byte is read in cycle N. S_WRITE is entered at N+1. i_wr_en/q_wr_en are high for exactly one cycle at N+2.
- Peak throughput: one pair per 5 cycles.
- The full flags are sampled in S_WRITE, one cycle before the strobe. Downstream FIFOs must provide at least one entry of slack past the full flag.
- Stalls:
  - Empty during byte collection adds cycles with no reads.
  - Full in S_WRITE stalls indefinitely with in_rd_en=0.

## Configuration
- IQ_SAMPLE_COUNT_EN:
  - Defined: sample_count port and a 32-bit counter exist. The counter increments by 1 in the same cycle i_wr_en is high and wraps from 0xFFFFFFFF to 0.
  - Undefined: neither the port nor the counter exists. All other behaviour is identical.

## Structure
- Shared macros package holds the BITS default constant and the QUANTIZE function (sign-extended 32-bit shift left by BITS). The complex FIR uses the same definitions via DEQUANTIZE.
- The FSM state enum is local to the module.
- No sub-module: byte capture, quantization and counter are inline. The input and output FIFOs are instantiated by the parent.

## Test plan
- Bytes 34 12 78 56 with BITS=10 and no stalls -> one write:
  - i_out=0x0048D000, q_out=0x0159E000.
  - Write strobe occurs 2 cycles after the last in_rd_en.
- Bytes 00 80 FF FF -> i_out=0xFE000000, q_out=0xFFFFFC00.
- in_empty toggled high for 3 cycles between every byte of the first-scenario pair -> identical output values, exactly one write, no extra in_rd_en pulses.
- q_full held high for 10 cycles on reaching S_WRITE, then released:
  - No wr_en and in_rd_en=0 during the hold.
  - Single paired write after release.
  - The next pair is then read correctly.
- Reset asserted after 2 bytes of a pair, then 4 fresh bytes AA 00 55 00 sent -> i_out=0x0002A800, q_out=0x00015400; no stale bytes appear.
- With IQ_SAMPLE_COUNT_EN, stream 3 pairs with full toggling -> sample_count=3, matching the count of i_wr_en pulses; sample_count=0 after reset.

Source files
------------

// File: rtl/iq_stream_splitter_pkg.sv
//------------------------------------------------------------------------------
// iq_stream_splitter_pkg
// Fixed-point constants and quantization helper shared by the I/Q datapath.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package iq_stream_splitter_pkg;

  localparam int c_BITS_DEFAULT = 10;

  // Sign-extend a 16-bit sample to 32 bits, then scale by 2**bits.
  function automatic logic [31:0] QUANTIZE(input logic [15:0] sample, input int bits);
    logic [31:0] w_ext;
    w_ext = {{16{sample[15]}}, sample};
    return w_ext << bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iq_stream_splitter.sv
//------------------------------------------------------------------------------
// iq_stream_splitter
// Reassembles little-endian I/Q byte pairs and writes quantized samples to
// paired I and Q FIFOs. Optional pair counter: IQ_SAMPLE_COUNT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iq_stream_splitter
  import iq_stream_splitter_pkg::*;
#(
  parameter int BITS = c_BITS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic [31:0] i_out,
  output logic [31:0] q_out,
  output logic        i_wr_en,
  output logic        q_wr_en,
  input  logic        i_full,
  input  logic        q_full
`ifdef IQ_SAMPLE_COUNT_EN
  ,
  output logic [31:0] sample_count
`endif
);

  typedef enum logic [2:0] {
    S_I_LO  = 3'd0,
    S_I_HI  = 3'd1,
    S_Q_LO  = 3'd2,
    S_Q_HI  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_rd;
  logic        w_wr;
  logic [7:0]  r_i_lo;
  logic [7:0]  r_i_hi;
  logic [7:0]  r_q_lo;
  logic [7:0]  r_q_hi;
  logic [31:0] r_i_out;
  logic [31:0] r_q_out;
  logic        r_wr_en;

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    case (r_state)
      S_I_LO:  if (!in_empty) begin w_rd = 1'b1; w_next = S_I_HI;  end
      S_I_HI:  if (!in_empty) begin w_rd = 1'b1; w_next = S_Q_LO;  end
      S_Q_LO:  if (!in_empty) begin w_rd = 1'b1; w_next = S_Q_HI;  end
      S_Q_HI:  if (!in_empty) begin w_rd = 1'b1; w_next = S_WRITE; end
      S_WRITE: if (!i_full && !q_full) begin w_wr = 1'b1; w_next = S_I_LO; end
      default: w_next = S_I_LO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_I_LO;
      r_i_lo  <= 8'h00;
      r_i_hi  <= 8'h00;
      r_q_lo  <= 8'h00;
      r_q_hi  <= 8'h00;
      r_i_out <= 32'h0;
      r_q_out <= 32'h0;
      r_wr_en <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wr_en <= w_wr;
      if (w_rd) begin
        case (r_state)
          S_I_LO:  r_i_lo <= din;
          S_I_HI:  r_i_hi <= din;
          S_Q_LO:  r_q_lo <= din;
          S_Q_HI:  r_q_hi <= din;
          default: ;
        endcase
      end
      // Both outputs load together so a pair can never be split.
      if (w_wr) begin
        r_i_out <= QUANTIZE({r_i_hi, r_i_lo}, BITS);
        r_q_out <= QUANTIZE({r_q_hi, r_q_lo}, BITS);
      end
    end
  end

`ifdef IQ_SAMPLE_COUNT_EN
  logic [31:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= 32'h0;
    end else if (w_wr) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign sample_count = r_count;
`endif

  // The FSM sits in S_I_LO during reset, so the read strobe is gated explicitly.
  assign in_rd_en = w_rd & ~reset;
  assign i_out    = r_i_out;
  assign q_out    = r_q_out;
  assign i_wr_en  = r_wr_en;
  assign q_wr_en  = r_wr_en;

endmodule

`default_nettype wire

// File: tb/tb_iq_stream_splitter.sv
//------------------------------------------------------------------------------
// tb_iq_stream_splitter
// Directed self-checking bench with a byte-level behavioural model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_iq_stream_splitter;

  localparam int BITS = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        in_empty = 1'b1;
  wire         in_rd_en;
  wire  [31:0] i_out;
  wire  [31:0] q_out;
  wire         i_wr_en;
  wire         q_wr_en;
  logic        i_full = 1'b0;
  logic        q_full = 1'b0;
`ifdef IQ_SAMPLE_COUNT_EN
  wire  [31:0] sample_count;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  iq_stream_splitter #(.BITS(BITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .din      (din),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .i_out    (i_out),
    .q_out    (q_out),
    .i_wr_en  (i_wr_en),
    .q_wr_en  (q_wr_en),
    .i_full   (i_full),
    .q_full   (q_full)
`ifdef IQ_SAMPLE_COUNT_EN
    ,
    .sample_count (sample_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] qmodel(input logic [7:0] lo, input logic [7:0] hi);
    longint v;
    v = longint'($signed({hi, lo}));
    v = v * (longint'(1) << BITS);
    return v[31:0];
  endfunction

  // Input FIFO model: first-word-fall-through with optional empty gaps after each pop.
  logic [7:0] src[$];
  int gap_len  = 0;
  int gap_left = 0;

  task automatic refresh();
    in_empty = (gap_left > 0) || (src.size() == 0);
    din      = (src.size() > 0) ? src[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    src.push_back(b);
    refresh();
  endtask

  always @(posedge clock) begin
    logic took;
    took = in_rd_en;
    #1;
    if (took && src.size() > 0) begin
      void'(src.pop_front());
      gap_left = gap_len;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    refresh();
  end

  // Behavioural model and per-cycle comparison.
  logic [7:0]  bytes_q[4];
  int          nbytes = 0;
  bit          pending = 0;
  int          t4 = -1;
  int          due = -1;
  int          strobes = 0;
  int          last_t4 = 0;
  int          last_strobe = 0;
  logic [31:0] last_i = 0, last_q = 0;
  logic [31:0] exp_i[$], exp_q[$];

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      nbytes = 0; pending = 0; due = -1; strobes = 0;
      last_i = 0; last_q = 0;
      exp_i.delete(); exp_q.delete();
      chk("reset_rd_en", {31'b0, in_rd_en}, 32'd0);
      chk("reset_wr_en", {30'b0, i_wr_en, q_wr_en}, 32'd0);
      chk("reset_i_out", i_out, 32'd0);
      chk("reset_q_out", q_out, 32'd0);
`ifdef IQ_SAMPLE_COUNT_EN
      chk("reset_count", sample_count, 32'd0);
`endif
    end else begin
      chk("i_wr_en_timing", {31'b0, i_wr_en}, {31'b0, (cyc == due)});
      chk("q_wr_en_equal", {31'b0, q_wr_en}, {31'b0, i_wr_en});
      if (i_wr_en && exp_i.size() > 0) begin
        last_i = exp_i.pop_front();
        last_q = exp_q.pop_front();
        strobes++;
        last_strobe = cyc;
`ifdef IQ_SAMPLE_COUNT_EN
        chk("sample_count", sample_count, strobes);
`endif
      end
      if (cyc == due) begin
        pending = 0;
        due = -1;
      end
      chk("i_out", i_out, last_i);
      chk("q_out", q_out, last_q);
      if (pending)
        chk("rd_while_pair_held", {31'b0, in_rd_en}, 32'd0);
      else
        chk("rd_en", {31'b0, in_rd_en}, {31'b0, !in_empty});
      if (pending && due < 0 && cyc > t4 && !i_full && !q_full)
        due = cyc + 1;
      if (in_rd_en && !pending) begin
        bytes_q[nbytes] = din;
        nbytes++;
        if (nbytes == 4) begin
          exp_i.push_back(qmodel(bytes_q[0], bytes_q[1]));
          exp_q.push_back(qmodel(bytes_q[2], bytes_q[3]));
          nbytes = 0;
          pending = 1;
          t4 = cyc;
          last_t4 = cyc;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((src.size() != 0 || pending || nbytes != 0) && n < 300) begin
      @(posedge clock);
      n++;
    end
    if (n >= 300) chk("timeout", 32'd1, 32'd0);
    repeat (2) @(posedge clock);
    #2;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    push(a); push(b); push(c); push(d);
  endtask

  task automatic do_reset(input int n);
    @(posedge clock); #2;
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int s0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // Basic pair and minimum latency.
    @(posedge clock); #2;
    push_pair(8'h34, 8'h12, 8'h78, 8'h56);
    wait_idle();
    chk("s1_i_out", i_out, 32'h0048D000);
    chk("s1_q_out", q_out, 32'h0159E000);
    chk("s1_latency", last_strobe - last_t4, 32'd2);

    // Most negative I, minus one Q.
    push_pair(8'h00, 8'h80, 8'hFF, 8'hFF);
    wait_idle();
    chk("s2_i_out", i_out, 32'hFE000000);
    chk("s2_q_out", q_out, 32'hFFFFFC00);

    // Empty gaps of 3 cycles between bytes.
    s0 = strobes;
    gap_len = 3;
    push_pair(8'h34, 8'h12, 8'h78, 8'h56);
    wait_idle();
    gap_len = 0;
    chk("s3_i_out", i_out, 32'h0048D000);
    chk("s3_q_out", q_out, 32'h0159E000);
    chk("s3_writes", strobes - s0, 32'd1);

    // Q FIFO full on arrival at the write state, next pair queued behind it.
    s0 = strobes;
    q_full = 1'b1;
    push_pair(8'h78, 8'h56, 8'h34, 8'h12);
    push_pair(8'h01, 8'h00, 8'hFF, 8'h7F);
    begin
      int n;
      n = 0;
      while (!pending && n < 50) begin @(posedge clock); n++; end
      if (n >= 50) chk("s4_timeout", 32'd1, 32'd0);
    end
    repeat (10) @(posedge clock);
    #2;
    chk("s4_no_write_held", strobes - s0, 32'd0);
    q_full = 1'b0;
    wait_idle();
    chk("s4_writes", strobes - s0, 32'd2);
    chk("s4_i_out", i_out, 32'h00000400);
    chk("s4_q_out", q_out, 32'h01FFFC00);

    // Reset in the middle of a pair.
    push(8'h11); push(8'h22);
    repeat (6) @(posedge clock);
    do_reset(2);
    push_pair(8'hAA, 8'h00, 8'h55, 8'h00);
    wait_idle();
    chk("s5_i_out", i_out, 32'h0002A800);
    chk("s5_q_out", q_out, 32'h00015400);
    chk("s5_writes", strobes, 32'd1);

    // Three pairs with I FIFO full toggling.
    do_reset(2);
    fork
      begin
        repeat (30) begin @(posedge clock); #2 i_full = ~i_full; end
        i_full = 1'b0;
      end
    join_none
    push_pair(8'h01, 8'h00, 8'h02, 8'h00);
    push_pair(8'h03, 8'h00, 8'h04, 8'h00);
    push_pair(8'h05, 8'h00, 8'hFB, 8'hFF);
    repeat (35) @(posedge clock);
    wait_idle();
    chk("s6_writes", strobes, 32'd3);
    chk("s6_i_out", i_out, 32'h00001400);
    chk("s6_q_out", q_out, 32'hFFFFEC00);
`ifdef IQ_SAMPLE_COUNT_EN
    chk("s6_sample_count", sample_count, 32'd3);
    do_reset(2);
    @(negedge clock);
    chk("s6_count_after_reset", sample_count, 32'd0);
`endif

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
